// File: rtl/pong_pkg.sv
// Shared pong definitions: default field geometry, paddle slide states and the
// helpers that derive the paddle's travel limit and serve position.
package pong_pkg;

  localparam int FIELD_H_DEF = 480;
  localparam int PAD_H_DEF   = 80;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLIDE_UP = 2'd1,
    SLIDE_DN = 2'd2
  } slide_state_e;

  // Largest legal top-edge Y: the paddle's bottom edge touches the field floor.
  function automatic int max_y(input int field_h, input int pad_h);
    return field_h - pad_h;
  endfunction

  function automatic int centre_y(input int field_h, input int pad_h);
    return max_y(field_h, pad_h) / 2;
  endfunction

endpackage

// File: rtl/slide_tick.sv
// Pixel-rate divider for the paddle slide: counts enabled clocks and flags the
// cycle on which the paddle should move one pixel.
module slide_tick #(
  parameter int SLIDE_DIV = 250000
) (
  input  logic fingclock,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DW = (SLIDE_DIV > 1) ? $clog2(SLIDE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SLIDE_DIV - 1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;

  assign o_tick = i_en && (r_div == DIV_LAST);

  // Clear wins over counting; the count wraps to zero on the tick cycle.
  always_comb begin
    w_div_nxt = r_div;
    if (i_clr) begin
      w_div_nxt = '0;
    end else if (o_tick) begin
      w_div_nxt = '0;
    end else if (i_en) begin
      w_div_nxt = r_div + DW'(1);
    end else begin
      w_div_nxt = r_div;
    end
  end

  always_ff @(posedge fingclock or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= w_div_nxt;
    end
  end

endmodule

// File: rtl/paddle_slide.sv
// Turns one-cycle up/down move pulses into a paced multi-pixel slide of the
// paddle top edge. Define PADDLE_WRAP_EN to wrap at the field edges instead of clamping.
module paddle_slide
  import pong_pkg::*;
#(
  parameter int FIELD_H   = FIELD_H_DEF,
  parameter int PAD_H     = PAD_H_DEF,
  parameter int STEP      = 40,
  parameter int SLIDE_DIV = 250000,
  parameter int POS_W     = 10
) (
  input  logic             fingclock,
  input  logic             rst,
  input  logic             up_pulse,
  input  logic             down_pulse,
  input  logic             recenter,
  input  logic             freeze,
  output logic [POS_W-1:0] pad_y,
  output logic             moving
);

  localparam int MAXY   = max_y(FIELD_H, PAD_H);
  localparam int CENTRE = centre_y(FIELD_H, PAD_H);
  localparam int REM_W  = $clog2(2 * STEP + 1);

  localparam logic [POS_W-1:0] Y_MAX    = POS_W'(MAXY);
  localparam logic [POS_W-1:0] Y_CTR    = POS_W'(CENTRE);
  localparam logic [REM_W-1:0] REM_STEP = REM_W'(STEP);
  localparam logic [REM_W-1:0] REM_CAP  = REM_W'(2 * STEP);

  slide_state_e     r_state;
  logic [POS_W-1:0] r_y;
  logic [REM_W-1:0] r_rem;
  logic             r_moving;

  slide_state_e     w_nxt_state;
  slide_state_e     w_t_state;
  slide_state_e     w_dir;
  logic [POS_W-1:0] w_nxt_y;
  logic [REM_W-1:0] w_nxt_rem;
  logic [REM_W-1:0] w_t_rem;
  logic [REM_W:0]   w_sum;
  logic             w_tick;
  logic             w_en;
  logic             w_clr;

  assign w_en  = !freeze && (r_state != IDLE);
  assign pad_y = r_y;
  assign moving = r_moving;

  slide_tick #(
    .SLIDE_DIV (SLIDE_DIV)
  ) u_tick (
    .fingclock (fingclock),
    .rst       (rst),
    .i_en      (w_en),
    .i_clr     (w_clr),
    .o_tick    (w_tick)
  );

  // A pixel tick is resolved first (w_t_*), then any single pulse acts on that result.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_y     = r_y;
    w_nxt_rem   = r_rem;
    w_t_state   = r_state;
    w_t_rem     = r_rem;
    w_sum       = '0;
    w_dir       = IDLE;
    w_clr       = 1'b0;
    if (recenter) begin
      w_nxt_state = IDLE;
      w_nxt_y     = Y_CTR;
      w_nxt_rem   = '0;
      w_clr       = 1'b1;
    end else if (freeze) begin
      w_nxt_state = r_state;
    end else begin
      if (w_tick) begin
        case (r_state)
          SLIDE_UP: begin
            if (r_y == '0) begin
`ifdef PADDLE_WRAP_EN
              w_nxt_y = Y_MAX;
              w_t_rem = r_rem - REM_W'(1);
`else
              w_t_rem = '0;
`endif
            end else begin
              w_nxt_y = r_y - POS_W'(1);
              w_t_rem = r_rem - REM_W'(1);
            end
          end
          SLIDE_DN: begin
            if (r_y == Y_MAX) begin
`ifdef PADDLE_WRAP_EN
              w_nxt_y = '0;
              w_t_rem = r_rem - REM_W'(1);
`else
              w_t_rem = '0;
`endif
            end else begin
              w_nxt_y = r_y + POS_W'(1);
              w_t_rem = r_rem - REM_W'(1);
            end
          end
          default: begin
            w_t_rem = r_rem;
          end
        endcase
        if (w_t_rem == '0) begin
          w_t_state = IDLE;
        end else begin
          w_t_state = r_state;
        end
      end else begin
        w_t_state = r_state;
      end

      if (up_pulse ^ down_pulse) begin
        w_dir = up_pulse ? SLIDE_UP : SLIDE_DN;
        if (w_t_state == w_dir) begin
          // Extending a slide keeps the divider phase and caps the backlog.
          w_sum       = {1'b0, w_t_rem} + {1'b0, REM_STEP};
          w_nxt_rem   = (w_sum > {1'b0, REM_CAP}) ? REM_CAP : w_sum[REM_W-1:0];
          w_nxt_state = w_t_state;
        end else begin
          w_nxt_state = w_dir;
          w_nxt_rem   = REM_STEP;
          w_clr       = 1'b1;
        end
      end else begin
        w_nxt_state = w_t_state;
        w_nxt_rem   = w_t_rem;
      end
    end
  end

  always_ff @(posedge fingclock or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_y      <= Y_CTR;
      r_rem    <= '0;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_y      <= w_nxt_y;
      r_rem    <= w_nxt_rem;
      r_moving <= (w_nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_paddle_slide.sv
// Self-checking bench for paddle_slide with a small field (MAXY=16, CENTRE=8),
// directed scenarios plus randomized pulses against a behavioural model.
module tb_paddle_slide;

  localparam int FIELD_H   = 20;
  localparam int PAD_H     = 4;
  localparam int STEP      = 3;
  localparam int SLIDE_DIV = 4;
  localparam int POS_W     = 10;
  localparam int MAXY      = FIELD_H - PAD_H;
  localparam int CENTRE    = MAXY / 2;

  logic             fingclock = 1'b0;
  logic             rst = 1'b0;
  logic             up_pulse = 1'b0;
  logic             down_pulse = 1'b0;
  logic             recenter = 1'b0;
  logic             freeze = 1'b0;
  logic [POS_W-1:0] pad_y;
  logic             moving;

  int checks = 0;
  int errors = 0;

  // Reference: position, direction (-1 up, +1 down, 0 idle), pixels left, clocks since last move.
  int m_y, m_dir, m_rem, m_cnt;

  paddle_slide #(
    .FIELD_H   (FIELD_H),
    .PAD_H     (PAD_H),
    .STEP      (STEP),
    .SLIDE_DIV (SLIDE_DIV),
    .POS_W     (POS_W)
  ) dut (
    .fingclock  (fingclock),
    .rst        (rst),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .recenter   (recenter),
    .freeze     (freeze),
    .pad_y      (pad_y),
    .moving     (moving)
  );

  always #5 fingclock = ~fingclock;

  task automatic model_reset();
    m_y = CENTRE; m_dir = 0; m_rem = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic up, input logic dn, input logic rec, input logic frz);
    int d;
    if (rec) begin
      model_reset();
    end else if (!frz) begin
      if (m_dir != 0) begin
        m_cnt++;
        if (m_cnt == SLIDE_DIV) begin
          m_cnt = 0;
          if ((m_dir < 0 && m_y == 0) || (m_dir > 0 && m_y == MAXY)) begin
`ifdef PADDLE_WRAP_EN
            m_y = (m_dir < 0) ? MAXY : 0;
            m_rem--;
`else
            m_rem = 0;
`endif
          end else begin
            m_y += m_dir;
            m_rem--;
          end
          if (m_rem == 0) m_dir = 0;
        end
      end
      if (up != dn) begin
        d = up ? -1 : 1;
        if (m_dir == d) begin
          m_rem = (m_rem + STEP > 2 * STEP) ? 2 * STEP : m_rem + STEP;
        end else begin
          m_dir = d; m_rem = STEP; m_cnt = 0;
        end
      end
    end
  endtask

  // One clock: inputs applied from the falling edge, model advanced at the rising edge.
  task automatic step(input logic up, input logic dn, input logic rec, input logic frz);
    up_pulse = up; down_pulse = dn; recenter = rec; freeze = frz;
    @(posedge fingclock);
    model_step(up, dn, rec, frz);
    @(negedge fingclock);
    up_pulse = 1'b0; down_pulse = 1'b0; recenter = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reset pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
    @(negedge fingclock);
    model_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reset_release pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
  endtask

  task automatic test_single_up();
    int e;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b1) begin
      errors++;
      $display("FAIL single_up_accept pad_y=%0d exp=8 moving=%0b exp=1", pad_y, moving);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      e = 8 - i / 4;
      checks++;
      if (pad_y !== POS_W'(e) || moving !== (i < 12)) begin
        errors++;
        $display("FAIL single_up cycle %0d pad_y=%0d exp=%0d moving=%0b exp=%0b",
                 i, pad_y, e, moving, (i < 12));
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pad_y !== 10'd7 || moving !== 1'b1) begin
      errors++;
      $display("FAIL async_pre pad_y=%0d exp=7 moving=%0b exp=1", pad_y, moving);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
    model_reset();
    @(negedge fingclock);
    rst = 1'b0;
  endtask

  task automatic test_clamp();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (pad_y !== 10'd14 || moving !== 1'b0) begin
      errors++;
      $display("FAIL clamp_setup pad_y=%0d exp=14 moving=%0b exp=0", pad_y, moving);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (pad_y !== POS_W'(m_y) || moving !== (m_dir != 0)) begin
        errors++;
        $display("FAIL clamp cycle %0d pad_y=%0d exp=%0d moving=%0b exp=%0b",
                 i, pad_y, m_y, moving, (m_dir != 0));
      end
    end
    checks++;
`ifdef PADDLE_WRAP_EN
    if (pad_y !== 10'd3 || moving !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final pad_y=%0d exp=3 moving=%0b exp=0", pad_y, moving);
    end
`else
    if (pad_y !== 10'd16 || moving !== 1'b0) begin
      errors++;
      $display("FAIL clamp_final pad_y=%0d exp=16 moving=%0b exp=0", pad_y, moving);
    end
`endif
  endtask

  task automatic test_reverse();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, (i == 5), 1'b0, 1'b0);
      checks++;
      if (pad_y !== POS_W'(m_y) || moving !== (m_dir != 0)) begin
        errors++;
        $display("FAIL reverse cycle %0d pad_y=%0d exp=%0d moving=%0b exp=%0b",
                 i, pad_y, m_y, moving, (m_dir != 0));
      end
    end
    checks++;
    if (pad_y !== 10'd10 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reverse_final pad_y=%0d exp=10 moving=%0b exp=0", pad_y, moving);
    end
  endtask

  task automatic test_both_pulses();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL both_idle pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pad_y !== 10'd11 || moving !== 1'b0) begin
      errors++;
      $display("FAIL both_slide pad_y=%0d exp=11 moving=%0b exp=0", pad_y, moving);
    end
  endtask

  task automatic test_freeze();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step((i == 3), (i == 6), 1'b0, 1'b1);
      checks++;
      if (pad_y !== 10'd7 || moving !== 1'b1) begin
        errors++;
        $display("FAIL freeze cycle %0d pad_y=%0d exp=7 moving=%0b exp=1", i, pad_y, moving);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (pad_y !== POS_W'(m_y) || moving !== (m_dir != 0)) begin
        errors++;
        $display("FAIL freeze_resume cycle %0d pad_y=%0d exp=%0d moving=%0b exp=%0b",
                 i, pad_y, m_y, moving, (m_dir != 0));
      end
    end
    checks++;
    if (pad_y !== 10'd5 || moving !== 1'b0) begin
      errors++;
      $display("FAIL freeze_final pad_y=%0d exp=5 moving=%0b exp=0", pad_y, moving);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL recenter_freeze pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pad_y !== 10'd8 || moving !== 1'b0) begin
      errors++;
      $display("FAIL recenter_drop pad_y=%0d exp=8 moving=%0b exp=0", pad_y, moving);
    end
  endtask

  task automatic test_random();
    logic up, dn, rec, frz;
    frz = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      up  = ($urandom_range(0, 7) == 0);
      dn  = ($urandom_range(0, 7) == 0);
      rec = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) frz = ~frz;
      step(up, dn, rec, frz);
      checks++;
      if (pad_y !== POS_W'(m_y) || moving !== (m_dir != 0)) begin
        errors++;
        $display("FAIL random cycle %0d pad_y=%0d exp=%0d moving=%0b exp=%0b",
                 i, pad_y, m_y, moving, (m_dir != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_async_reset();
    test_clamp();
    test_reverse();
    test_both_pulses();
    test_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
